mesi_coherency_core: RTL and testbench

Single-agent, write-back, write-allocate data cache that tracks a MESI state per line in front of an internal word-addressed backing memory. It accepts one word read or word write at a time from a simple valid/response request port and reports hit/miss and error status. It sits between a processor-side load/store port and the memory model. It is the coherence-state engine of the `mesi_coherency` block.

---
 rtl/mesi_coherency_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mesi_coherency_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mesi_coherency_core.sv
// mesi_coherency_core
// Direct-mapped, write-back, write-allocate, one-word-per-line cache that keeps
// a MESI state per line, sitting in front of a word-addressed backing memory
// with a fixed access latency. One request is processed at a time. Response,
// hit flag and read data are held until the next request is accepted.
module mesi_coherency_core #(
  parameter int INDEX_BITS = 6,
  parameter int MEM_LAT    = 4
) (
  input  logic        clk,
  input  logic        rstn,        // synchronous, active-high despite the name
  input  logic [19:0] data_addr,
  input  logic [31:0] wdata,
  input  logic        awvalid,
  input  logic        wvalid,
  input  logic        arvalid,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        w_hit,
  output logic        r_hit,
  output logic [1:0]  w_resp,
  output logic [1:0]  r_resp
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int TAG_W  = 18 - INDEX_BITS;
  localparam int CNT_W  = $clog2(MEM_LAT + 1);
  localparam int MEM_WORDS = 1 << 18;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_E = 2'd2,
    ST_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } fsm_t;

  // Line storage and the backing memory. The memory model starts out zeroed
  // and is never touched by reset.
  logic [TAG_W-1:0] tag_arr   [LINES];
  logic [31:0]      data_arr  [LINES];
  mesi_t            state_arr [LINES];
  logic [31:0]      mem       [MEM_WORDS] = '{default: '0};

  // Latched request and result of the lookup/fill, presented in RESP.
  fsm_t              state_q, state_d;
  logic [17:0]       req_word_q;
  logic [31:0]       req_wdata_q;
  logic              req_write_q;
  logic              req_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              res_hit_q;
  logic [31:0]       res_data_q;

  // Control decoded from the current FSM state.
  logic              accept;
  logic              cnt_load;
  logic              line_we;
  logic [31:0]       line_wr_data;
  mesi_t             line_new_state;
  logic              mem_we;
  logic              res_we;
  logic              res_hit_d;
  logic [31:0]       res_data_d;

  // Address split of the held request and the line it maps to.
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  mesi_t                 line_state;
  logic                  line_hit;
  logic                  cnt_done;
  logic [31:0]           mem_rd;

  assign req_idx    = req_word_q[INDEX_BITS-1:0];
  assign req_tag    = req_word_q[17:INDEX_BITS];
  assign line_tag   = tag_arr[req_idx];
  assign line_data  = data_arr[req_idx];
  assign line_state = state_arr[req_idx];
  assign line_hit   = (line_tag == req_tag) && (line_state != ST_I);
  assign cnt_done   = (cnt_q == '0);
  assign mem_rd     = mem[req_word_q];

  assign rvalid = r_resp[0] & ~r_resp[1];

  // Next-state and per-state control: accept, lookup, writeback, fill, respond.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // leaves one unassigned would infer a latch.
    state_d        = state_q;
    accept         = 1'b0;
    cnt_load       = 1'b0;
    line_we        = 1'b0;
    line_wr_data   = req_wdata_q;
    line_new_state = ST_I;
    mem_we         = 1'b0;
    res_we         = 1'b0;
    res_hit_d      = 1'b0;
    res_data_d     = '0;

    case (state_q)
      IDLE: begin
        if (awvalid || arvalid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (req_err_q) begin
          // Error: record a miss with zero data, leave cache and memory alone.
          res_we  = 1'b1;
          state_d = RESP;
        end else if (line_hit) begin
          res_we    = 1'b1;
          res_hit_d = 1'b1;
          if (req_write_q) begin
            // Hits in E and M, and the S upgrade (no other agents to
            // invalidate), all complete immediately and leave the line M.
            line_we        = 1'b1;
            line_wr_data   = req_wdata_q;
            line_new_state = ST_M;
          end else begin
            res_data_d = line_data;
          end
          state_d = RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = (line_state == ST_M) ? WB : FILL;
        end
      end

      WB: begin
        if (cnt_done) begin
          mem_we   = 1'b1;
          cnt_load = 1'b1;
          state_d  = FILL;
        end
      end

      FILL: begin
        if (cnt_done) begin
          line_we = 1'b1;
          res_we  = 1'b1;
          if (req_write_q) begin
            // Read-for-ownership: the whole word is replaced by wdata.
            line_wr_data   = req_wdata_q;
            line_new_state = ST_M;
          end else begin
            // No sharers exist, so a read fill is exclusive.
            line_wr_data   = mem_rd;
            line_new_state = ST_E;
            res_data_d     = mem_rd;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, request capture, latency counter and sticky response registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rstn) begin
      state_q     <= IDLE;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      req_err_q   <= 1'b0;
      cnt_q       <= '0;
      res_hit_q   <= 1'b0;
      res_data_q  <= '0;
      rdata       <= '0;
      w_hit       <= 1'b0;
      r_hit       <= 1'b0;
      w_resp      <= 2'b00;
      r_resp      <= 2'b00;
    end else begin
      state_q <= state_d;

      if (accept) begin
        // A write (awvalid) always takes priority over a simultaneous read.
        req_word_q  <= data_addr[19:2];
        req_wdata_q <= wdata;
        req_write_q <= awvalid;
        req_err_q   <= (data_addr[1:0] != 2'b00) || (awvalid && !wvalid);
        rdata       <= '0;
        w_hit       <= 1'b0;
        r_hit       <= 1'b0;
        w_resp      <= 2'b00;
        r_resp      <= 2'b00;
      end

      if (cnt_load) begin
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if ((state_q == WB || state_q == FILL) && !cnt_done) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (res_we) begin
        res_hit_q  <= res_hit_d;
        res_data_q <= res_data_d;
      end

      if (state_q == RESP) begin
        if (req_write_q) begin
          w_resp <= {req_err_q, 1'b1};
          w_hit  <= res_hit_q;
        end else begin
          r_resp <= {req_err_q, 1'b1};
          r_hit  <= res_hit_q;
          rdata  <= res_data_q;
        end
      end
    end
  end

  // Line states: reset invalidates every line, dropping any dirty data.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < LINES; i++) begin
        state_arr[i] <= ST_I;
      end
    end else if (line_we) begin
      state_arr[req_idx] <= line_new_state;
    end
  end

  // Line tag and data: no reset needed, an I state makes the contents dead.
  always_ff @(posedge clk) begin
    // NOTE: tag/data storage is deliberately not reset; clearing the state
    // array alone is enough and keeps these arrays mappable to RAM.
    if (!rstn && line_we) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= line_wr_data;
    end
  end

  // Backing memory write port: victim writeback at the end of WB.
  always_ff @(posedge clk) begin
    if (!rstn && mem_we) begin
      mem[{line_tag, req_idx}] <= line_data;
    end
  end

endmodule

// File: tb/tb_mesi_coherency_core.sv
// Testbench for mesi_coherency_core: a table of directed requests with
// hand-computed responses and latencies, plus a hand-written sequence that
// resets the block in the middle of a dirty-miss writeback.
module tb_mesi_coherency_core;

  localparam int L      = 4;
  localparam int LAT_HIT   = 2;
  localparam int LAT_CLEAN = 2 + L;
  localparam int LAT_DIRTY = 2 + 2 * L;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BOTH, OP_AW} op_t;

  typedef struct {
    op_t         op;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic [19:0] data_addr;
  logic [31:0] wdata;
  logic        awvalid;
  logic        wvalid;
  logic        arvalid;
  logic        rvalid;
  logic [31:0] rdata;
  logic        w_hit;
  logic        r_hit;
  logic [1:0]  w_resp;
  logic [1:0]  r_resp;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vec [16];

  mesi_coherency_core #(.INDEX_BITS(6), .MEM_LAT(L)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_addr (data_addr),
    .wdata     (wdata),
    .awvalid   (awvalid),
    .wvalid    (wvalid),
    .arvalid   (arvalid),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .w_hit     (w_hit),
    .r_hit     (r_hit),
    .w_resp    (w_resp),
    .r_resp    (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " rvalid"}, 32'(rvalid), 32'd0);
    check({name, " rdata"},  rdata,       32'd0);
    check({name, " w_hit"},  32'(w_hit),  32'd0);
    check({name, " r_hit"},  32'(r_hit),  32'd0);
    check({name, " w_resp"}, 32'(w_resp), 32'd0);
    check({name, " r_resp"}, 32'(r_resp), 32'd0);
  endtask

  // Issue one request, wait (bounded) for its response and compare everything.
  task automatic run_req(input string name, input vec_t v);
    int  lat;
    bit  seen;
    bit  is_w;
    is_w = (v.op != OP_RD);
    @(negedge clk);
    data_addr = v.addr;
    wdata     = v.wdata;
    awvalid   = (v.op == OP_WR) || (v.op == OP_BOTH) || (v.op == OP_AW);
    wvalid    = (v.op == OP_WR) || (v.op == OP_BOTH);
    arvalid   = (v.op == OP_RD) || (v.op == OP_BOTH);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    check({name, " cleared"}, {28'd0, w_resp, r_resp}, 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      lat++;
      seen = is_w ? w_resp[0] : r_resp[0];
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no response after %0d cycles, required %0d", name, lat, v.exp_lat);
      return;
    end
    check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
    if (is_w) begin
      check({name, " w_resp"}, 32'(w_resp), 32'(v.exp_resp));
      check({name, " w_hit"},  32'(w_hit),  32'(v.exp_hit));
      check({name, " r_resp"}, 32'(r_resp), 32'd0);
      check({name, " rvalid"}, 32'(rvalid), 32'd0);
    end else begin
      check({name, " r_resp"}, 32'(r_resp), 32'(v.exp_resp));
      check({name, " r_hit"},  32'(r_hit),  32'(v.exp_hit));
      check({name, " rdata"},  rdata,       v.exp_rdata);
      check({name, " rvalid"}, 32'(rvalid), 32'(v.exp_resp == 2'b01));
      check({name, " w_resp"}, 32'(w_resp), 32'd0);
    end
  endtask

  initial begin
    vec_t v;

    //            op       addr       wdata         resp   hit   rdata         latency
    vec[0]  = '{OP_RD,   20'h00010, 32'h0,        2'b01, 1'b0, 32'h0,        LAT_CLEAN}; // cold read -> E
    vec[1]  = '{OP_WR,   20'h00010, 32'hDEADBEEF, 2'b01, 1'b1, 32'h0,        LAT_HIT};   // E -> M
    vec[2]  = '{OP_RD,   20'h00010, 32'h0,        2'b01, 1'b1, 32'hDEADBEEF, LAT_HIT};   // back-to-back hit
    vec[3]  = '{OP_WR,   20'h00010, 32'h00000001, 2'b01, 1'b1, 32'h0,        LAT_HIT};
    vec[4]  = '{OP_WR,   20'h00110, 32'h00000002, 2'b01, 1'b0, 32'h0,        LAT_DIRTY}; // conflict, evict M
    vec[5]  = '{OP_RD,   20'h00010, 32'h0,        2'b01, 1'b0, 32'h00000001, LAT_DIRTY}; // written-back 1
    vec[6]  = '{OP_RD,   20'h00110, 32'h0,        2'b01, 1'b0, 32'h00000002, LAT_CLEAN}; // written-back 2
    vec[7]  = '{OP_WR,   20'h00012, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        LAT_HIT};   // misaligned write
    vec[8]  = '{OP_RD,   20'h00110, 32'h0,        2'b01, 1'b1, 32'h00000002, LAT_HIT};   // line untouched
    vec[9]  = '{OP_RD,   20'h00003, 32'h0,        2'b11, 1'b0, 32'h0,        LAT_HIT};   // misaligned read
    vec[10] = '{OP_BOTH, 20'h00020, 32'h00000055, 2'b01, 1'b0, 32'h0,        LAT_CLEAN}; // write wins
    vec[11] = '{OP_RD,   20'h00020, 32'h0,        2'b01, 1'b1, 32'h00000055, LAT_HIT};
    vec[12] = '{OP_AW,   20'h00024, 32'h12345678, 2'b11, 1'b0, 32'h0,        LAT_HIT};   // no wvalid
    vec[13] = '{OP_RD,   20'h00024, 32'h0,        2'b01, 1'b0, 32'h0,        LAT_CLEAN}; // memory unchanged
    vec[14] = '{OP_WR,   20'h00040, 32'hCAFEF00D, 2'b01, 1'b0, 32'h0,        LAT_CLEAN}; // line 16 -> M
    vec[15] = '{OP_RD,   20'h00040, 32'h0,        2'b01, 1'b1, 32'hCAFEF00D, LAT_HIT};

    rstn      = 1'b1;
    data_addr = '0;
    wdata     = '0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    arvalid   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_req($sformatf("v%0d", i), vec[i]);
    end

    // Reset in the middle of the writeback caused by evicting dirty 0x00040.
    @(negedge clk);
    data_addr = 20'h00140;
    wdata     = 32'h00000077;
    awvalid   = 1'b1;
    wvalid    = 1'b1;
    @(posedge clk);               // accepted
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(posedge clk);               // lookup: dirty miss, enter WB
    @(posedge clk);               // first WB cycle
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_wb_reset");
    @(negedge clk);
    rstn = 1'b0;
    repeat (2 * LAT_DIRTY) @(posedge clk);
    #1;
    check_all_zero("no_resp_after_abort");

    // Dirty data was discarded and the writeback never reached memory.
    v = '{OP_RD, 20'h00040, 32'h0, 2'b01, 1'b0, 32'h0, LAT_CLEAN};
    run_req("post_reset_rd_evicted", v);
    v = '{OP_RD, 20'h00140, 32'h0, 2'b01, 1'b0, 32'h0, LAT_CLEAN};
    run_req("post_reset_rd_new", v);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
